// File: rtl/spmv_csr_loader.sv
// spmv_csr_loader: writer side of the SpMV SRAM interface.
// Collects a 16-entry dense vector and a row-major stream of nonzeros. It packs
// them into the CSR layout that the SpMV engine reads, then writes:
//   SRAM A: word IV_ADDR = input vector, words VAL_BASE.. = values (16 per word)
//   SRAM B: word RP_ADDR = row_ptr[0..16], words CI_BASE.. = col_idx (64 per word)
// Optional feature macro: SPMV_LOADER_ZERO_SKIP_EN. When it is defined, nonzero
// beats carrying a zero value are consumed without being stored.

module spmv_csr_loader #(
    parameter int DATA_W   = 16,
    parameter int IDX_W    = 4,
    parameter int PTR_W    = 8,
    parameter int ADDR_W   = 5,
    parameter int IV_ADDR  = 0,
    parameter int VAL_BASE = 1,
    parameter int RP_ADDR  = 0,
    parameter int CI_BASE  = 1
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_start,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [IDX_W-1:0]  i_row,
    input  logic [IDX_W-1:0]  i_col,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_last,
    output logic              o_wr_en_A,
    output logic [ADDR_W-1:0] o_address_A,
    output logic [255:0]      o_wdata_A,
    output logic              o_wr_en_B,
    output logic [ADDR_W-1:0] o_address_B,
    output logic [255:0]      o_wdata_B,
    output logic [PTR_W-1:0]  o_nnz,
    output logic [2:0]        o_state,
    output logic              o_error,
    output logic              o_done
);

    localparam int WORD_W  = 256;
    localparam int N       = 1 << IDX_W;
    localparam int VSLOT_W = $clog2(WORD_W / DATA_W);
    localparam int CSLOT_W = $clog2(WORD_W / IDX_W);
    localparam logic [PTR_W-1:0] MAX_NNZ = '1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD_IV  = 3'd1,
        S_LOAD_NZ  = 3'd2,
        S_FLUSH    = 3'd3,
        S_WRITE_RP = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    iv_cnt_q, iv_cnt_d;
    logic [WORD_W-1:0]   pack_a_q, pack_a_d;
    logic [WORD_W-1:0]   pack_b_q, pack_b_d;
    logic [PTR_W-1:0]    nnz_q, nnz_d;
    logic [IDX_W-1:0]    cur_row_q, cur_row_d;
    logic [PTR_W-1:0]    ptr_q [0:N];
    logic [PTR_W-1:0]    ptr_d [0:N];
    logic                error_q, error_d;
    logic                wr_a_q, wr_a_d;
    logic [ADDR_W-1:0]   addr_a_q, addr_a_d;
    logic [WORD_W-1:0]   wdata_a_q, wdata_a_d;
    logic                wr_b_q, wr_b_d;
    logic [ADDR_W-1:0]   addr_b_q, addr_b_d;
    logic [WORD_W-1:0]   wdata_b_q, wdata_b_d;
    logic                done_q, done_d;

    logic                beat;
    logic                skip;
    logic                bad;
    logic                store;
    logic [VSLOT_W-1:0]  slot_a;
    logic [CSLOT_W-1:0]  slot_b;
    logic [PTR_W-1:0]    wr_idx;
    logic                fire_a;
    logic                fire_b;
    logic [IDX_W-1:0]    row_new;
    logic [PTR_W-1:0]    nnz_new;
    logic [WORD_W-1:0]   rp_word;

    assign o_ready = (state_q == S_LOAD_IV) || (state_q == S_LOAD_NZ);
    assign beat    = i_valid && o_ready;

`ifdef SPMV_LOADER_ZERO_SKIP_EN
    assign skip = (i_data == '0);
`else
    assign skip = 1'b0;
`endif

    // A beat is dropped when its row goes backwards or the nonzero budget is exhausted.
    // Skipped zero values bypass this check entirely.
    assign bad    = !skip && ((i_row < cur_row_q) || (nnz_q == MAX_NNZ));
    assign store  = beat && (state_q == S_LOAD_NZ) && !skip && !bad;
    assign slot_a = nnz_q[VSLOT_W-1:0];
    assign slot_b = nnz_q[CSLOT_W-1:0];

    // Word being closed: the current one on a stored beat, or the last partially
    // filled one when i_last arrives on a beat that is not stored.
    assign wr_idx = store ? nnz_q : nnz_q - 1'b1;
    assign fire_a = beat && (state_q == S_LOAD_NZ) &&
                    (store ? ((slot_a == '1) || i_last) : (i_last && (slot_a != '0)));
    assign fire_b = beat && (state_q == S_LOAD_NZ) &&
                    (store ? ((slot_b == '1) || i_last) : (i_last && (slot_b != '0)));

    assign o_wr_en_A   = wr_a_q;
    assign o_address_A = addr_a_q;
    assign o_wdata_A   = wdata_a_q;
    assign o_wr_en_B   = wr_b_q;
    assign o_address_B = addr_b_q;
    assign o_wdata_B   = wdata_b_q;
    assign o_nnz       = nnz_q;
    assign o_state     = state_q;
    assign o_error     = error_q;
    assign o_done      = done_q;

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (i_start) state_d = S_LOAD_IV;
            S_LOAD_IV:  if (beat && (iv_cnt_q == IDX_W'(N - 1))) state_d = S_LOAD_NZ;
            S_LOAD_NZ:  if (beat && i_last) state_d = S_FLUSH;
            S_FLUSH:    state_d = S_WRITE_RP;
            S_WRITE_RP: state_d = S_DONE;
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Pack row_ptr[0..16] into the low bits of the SRAM B word, upper bits zero
    always_comb begin
        rp_word = '0;
        for (int k = 0; k <= N; k++) rp_word[k*PTR_W +: PTR_W] = ptr_q[k];
    end

    // FSM output logic: packing, row_ptr tracking and next values of the registered write ports
    always_comb begin
        iv_cnt_d  = iv_cnt_q;
        pack_a_d  = pack_a_q;
        pack_b_d  = pack_b_q;
        nnz_d     = nnz_q;
        cur_row_d = cur_row_q;
        ptr_d     = ptr_q;
        error_d   = error_q;
        row_new   = cur_row_q;
        nnz_new   = nnz_q;
        wr_a_d    = 1'b0;
        addr_a_d  = '0;
        wdata_a_d = '0;
        wr_b_d    = 1'b0;
        addr_b_d  = '0;
        wdata_b_d = '0;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    iv_cnt_d  = '0;
                    pack_a_d  = '0;
                    pack_b_d  = '0;
                    nnz_d     = '0;
                    cur_row_d = '0;
                    error_d   = 1'b0;
                    for (int k = 0; k <= N; k++) ptr_d[k] = '0;
                end
            end
            S_LOAD_IV: begin
                if (beat) begin
                    pack_a_d[int'(iv_cnt_q)*DATA_W +: DATA_W] = i_data;
                    iv_cnt_d = iv_cnt_q + 1'b1;
                    if (iv_cnt_q == IDX_W'(N - 1)) begin
                        wr_a_d    = 1'b1;
                        addr_a_d  = ADDR_W'(IV_ADDR);
                        wdata_a_d = pack_a_d;
                        pack_a_d  = '0;
                    end
                end
            end
            S_LOAD_NZ: begin
                if (beat) begin
                    if (bad) error_d = 1'b1;
                    if (store) begin
                        pack_a_d[int'(slot_a)*DATA_W +: DATA_W] = i_data;
                        pack_b_d[int'(slot_b)*IDX_W +: IDX_W]   = i_col;
                        // Rows skipped over start at the current count
                        for (int k = 1; k <= N; k++)
                            if ((k > int'(cur_row_q)) && (k <= int'(i_row))) ptr_d[k] = nnz_q;
                        row_new = i_row;
                        nnz_new = nnz_q + 1'b1;
                    end
                    // Every row after the last one seen is empty and ends at the final count
                    if (i_last)
                        for (int k = 1; k <= N; k++)
                            if (k > int'(row_new)) ptr_d[k] = nnz_new;
                    nnz_d     = nnz_new;
                    cur_row_d = row_new;
                    if (fire_a) begin
                        wr_a_d    = 1'b1;
                        addr_a_d  = ADDR_W'(VAL_BASE) + ADDR_W'(wr_idx >> VSLOT_W);
                        wdata_a_d = pack_a_d;
                        pack_a_d  = '0;
                    end
                    if (fire_b) begin
                        wr_b_d    = 1'b1;
                        addr_b_d  = ADDR_W'(CI_BASE) + ADDR_W'(wr_idx >> CSLOT_W);
                        wdata_b_d = pack_b_d;
                        pack_b_d  = '0;
                    end
                end
            end
            S_FLUSH: begin
                wr_b_d    = 1'b1;
                addr_b_d  = ADDR_W'(RP_ADDR);
                wdata_b_d = rp_word;
            end
            S_WRITE_RP: done_d = 1'b1;
            default: ;
        endcase
    end

    // Datapath and output registers; reset aborts any load and drops pending writes
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            iv_cnt_q  <= '0;
            pack_a_q  <= '0;
            pack_b_q  <= '0;
            nnz_q     <= '0;
            cur_row_q <= '0;
            for (int k = 0; k <= N; k++) ptr_q[k] <= '0;
            error_q   <= 1'b0;
            wr_a_q    <= 1'b0;
            addr_a_q  <= '0;
            wdata_a_q <= '0;
            wr_b_q    <= 1'b0;
            addr_b_q  <= '0;
            wdata_b_q <= '0;
            done_q    <= 1'b0;
        end else begin
            iv_cnt_q  <= iv_cnt_d;
            pack_a_q  <= pack_a_d;
            pack_b_q  <= pack_b_d;
            nnz_q     <= nnz_d;
            cur_row_q <= cur_row_d;
            for (int k = 0; k <= N; k++) ptr_q[k] <= ptr_d[k];
            error_q   <= error_d;
            wr_a_q    <= wr_a_d;
            addr_a_q  <= addr_a_d;
            wdata_a_q <= wdata_a_d;
            wr_b_q    <= wr_b_d;
            addr_b_q  <= addr_b_d;
            wdata_b_q <= wdata_b_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_spmv_csr_loader.sv
// Testbench for spmv_csr_loader: scoreboard of expected SRAM A/B writes plus
// per-scenario checks of state, latency, counters and error flag.
module tb_spmv_csr_loader;

    logic         i_clk = 1'b0;
    logic         i_rstn = 1'b0;
    logic         i_start = 1'b0;
    logic         i_valid = 1'b0;
    logic         o_ready;
    logic [3:0]   i_row = '0;
    logic [3:0]   i_col = '0;
    logic [15:0]  i_data = '0;
    logic         i_last = 1'b0;
    logic         o_wr_en_A, o_wr_en_B;
    logic [4:0]   o_address_A, o_address_B;
    logic [255:0] o_wdata_A, o_wdata_B;
    logic [7:0]   o_nnz;
    logic [2:0]   o_state;
    logic         o_error, o_done;

    typedef struct packed {
        logic [4:0]   addr;
        logic [255:0] data;
    } wr_t;

    wr_t          exp_a[$];
    wr_t          exp_b[$];
    wr_t          ea, eb;
    int           checks = 0;
    int           failures = 0;
    logic [3:0]   bt_row [0:299];
    logic [3:0]   bt_col [0:299];
    logic [15:0]  bt_val [0:299];
    logic [15:0]  vec [0:15];
    int           m_nnz;
    bit           m_err;
    logic [255:0] last_rp = '0;

    spmv_csr_loader dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_start(i_start), .i_valid(i_valid),
        .o_ready(o_ready), .i_row(i_row), .i_col(i_col), .i_data(i_data),
        .i_last(i_last), .o_wr_en_A(o_wr_en_A), .o_address_A(o_address_A),
        .o_wdata_A(o_wdata_A), .o_wr_en_B(o_wr_en_B), .o_address_B(o_address_B),
        .o_wdata_B(o_wdata_B), .o_nnz(o_nnz), .o_state(o_state),
        .o_error(o_error), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

    // Scoreboard: every SRAM write must match the next expected write for that port
    always @(negedge i_clk) begin
        if (o_wr_en_A) begin
            checks = checks + 1;
            if (exp_a.size() == 0) begin
                failures = failures + 1;
                $display("FAIL wrA_unexpected addr=%0d data=%h", o_address_A, o_wdata_A);
            end else begin
                ea = exp_a.pop_front();
                if (o_address_A !== ea.addr || o_wdata_A !== ea.data) begin
                    failures = failures + 1;
                    $display("FAIL wrA got addr=%0d data=%h exp addr=%0d data=%h",
                             o_address_A, o_wdata_A, ea.addr, ea.data);
                end
            end
        end
        if (o_wr_en_B) begin
            if (o_address_B == 5'd0) last_rp = o_wdata_B;
            checks = checks + 1;
            if (exp_b.size() == 0) begin
                failures = failures + 1;
                $display("FAIL wrB_unexpected addr=%0d data=%h", o_address_B, o_wdata_B);
            end else begin
                eb = exp_b.pop_front();
                if (o_address_B !== eb.addr || o_wdata_B !== eb.data) begin
                    failures = failures + 1;
                    $display("FAIL wrB got addr=%0d data=%h exp addr=%0d data=%h",
                             o_address_B, o_wdata_B, eb.addr, eb.data);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Reference: filter beats, then lay values/cols into words and count rows below each k
    task automatic model_push(input int nb);
        logic [15:0]  vals[$];
        logic [3:0]   cols[$];
        logic [3:0]   rows[$];
        logic [255:0] word;
        int           cur;
        int           cnt;
        bit           skip;
        cur = 0;
        m_err = 1'b0;
        for (int j = 0; j < nb; j++) begin
            skip = 1'b0;
`ifdef SPMV_LOADER_ZERO_SKIP_EN
            skip = (bt_val[j] == 16'd0);
`endif
            if (!skip) begin
                if (int'(bt_row[j]) < cur || vals.size() == 255) begin
                    m_err = 1'b1;
                end else begin
                    cur = int'(bt_row[j]);
                    vals.push_back(bt_val[j]);
                    cols.push_back(bt_col[j]);
                    rows.push_back(bt_row[j]);
                end
            end
        end
        m_nnz = vals.size();
        for (int w = 0; w * 16 < vals.size(); w++) begin
            word = '0;
            for (int s = 0; s < 16 && w * 16 + s < vals.size(); s++) word[s*16 +: 16] = vals[w*16+s];
            exp_a.push_back(wr_t'{addr: 5'(1 + w), data: word});
        end
        for (int w = 0; w * 64 < cols.size(); w++) begin
            word = '0;
            for (int s = 0; s < 64 && w * 64 + s < cols.size(); s++) word[s*4 +: 4] = cols[w*64+s];
            exp_b.push_back(wr_t'{addr: 5'(1 + w), data: word});
        end
        word = '0;
        for (int k = 0; k <= 16; k++) begin
            cnt = 0;
            for (int i = 0; i < rows.size(); i++) if (int'(rows[i]) < k) cnt++;
            word[k*8 +: 8] = 8'(cnt);
        end
        exp_b.push_back(wr_t'{addr: 5'd0, data: word});
    endtask

    task automatic drive_beat(input logic [3:0] r, input logic [3:0] c, input logic [15:0] d,
                              input logic l);
        i_valid = 1'b1; i_row = r; i_col = c; i_data = d; i_last = l;
        @(posedge i_clk); #1;
        i_valid = 1'b0; i_last = 1'b0;
    endtask

    task automatic do_start();
        i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
    endtask

    task automatic load_vector();
        logic [255:0] word;
        word = '0;
        for (int k = 0; k < 16; k++) word[k*16 +: 16] = vec[k];
        exp_a.push_back(wr_t'{addr: 5'd0, data: word});
        for (int k = 0; k < 16; k++) drive_beat(4'd0, 4'd0, vec[k], 1'b0);
    endtask

    task automatic run_nz(input int nb);
        for (int j = 0; j < nb; j++) drive_beat(bt_row[j], bt_col[j], bt_val[j], j == nb - 1);
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (o_done === 1'b1) seen = 1'b1;
            else begin @(posedge i_clk); #1; end
        end
        @(posedge i_clk); #1;
    endtask

    task automatic rand_vector();
        for (int k = 0; k < 16; k++) vec[k] = 16'($urandom);
    endtask

    task automatic test_reset();
        i_rstn = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        checks++; if (o_state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", o_state); end
        checks++; if ({o_ready, o_wr_en_A, o_wr_en_B, o_done, o_error} !== 5'b0) begin
            failures++; $display("FAIL reset_flags got=%b exp=00000", {o_ready, o_wr_en_A, o_wr_en_B, o_done, o_error}); end
        checks++; if (o_nnz !== 8'd0) begin failures++; $display("FAIL reset_nnz got=%0d exp=0", o_nnz); end
        checks++; if ({o_address_A, o_address_B} !== 10'd0 || (o_wdata_A | o_wdata_B) !== 256'd0) begin
            failures++; $display("FAIL reset_bus got=%h/%h exp=0", o_address_A, o_address_B); end
        #3 i_rstn = 1'b1;
        @(posedge i_clk); #1;
        checks++; if (o_state !== 3'd0) begin failures++; $display("FAIL idle_after_reset got=%0d exp=0", o_state); end
    endtask

    task automatic test_basic();
        logic [255:0] rp;
        for (int k = 0; k < 16; k++) vec[k] = 16'(k + 1);
        do_start();
        checks++; if ({o_state, o_ready} !== {3'd1, 1'b1}) begin
            failures++; $display("FAIL basic_loadiv got=%0d/%b exp=1/1", o_state, o_ready); end
        load_vector();
        checks++; if ({o_state, o_wr_en_A, o_address_A} !== {3'd2, 1'b1, 5'd0}) begin
            failures++; $display("FAIL basic_iv_write got=%0d/%b/%0d exp=2/1/0", o_state, o_wr_en_A, o_address_A); end
        bt_row[0] = 4'd0; bt_col[0] = 4'd0; bt_val[0] = 16'd7;
        model_push(1);
        run_nz(1);
        checks++; if ({o_state, o_wr_en_A, o_address_A, o_wr_en_B, o_address_B} !== {3'd3, 1'b1, 5'd1, 1'b1, 5'd1}) begin
            failures++; $display("FAIL basic_flush got=%0d/%b/%0d/%b/%0d exp=3/1/1/1/1",
                                 o_state, o_wr_en_A, o_address_A, o_wr_en_B, o_address_B); end
        @(posedge i_clk); #1;
        rp = '0;
        for (int k = 1; k <= 16; k++) rp[k*8 +: 8] = 8'd1;
        checks++; if ({o_state, o_wr_en_B, o_address_B} !== {3'd4, 1'b1, 5'd0} || o_wdata_B !== rp) begin
            failures++; $display("FAIL basic_rp got=%0d/%b/%0d/%h exp=4/1/0/%h",
                                 o_state, o_wr_en_B, o_address_B, o_wdata_B, rp); end
        @(posedge i_clk); #1;
        checks++; if ({o_state, o_done} !== {3'd5, 1'b1}) begin
            failures++; $display("FAIL basic_done got=%0d/%b exp=5/1", o_state, o_done); end
        @(posedge i_clk); #1;
        checks++; if ({o_state, o_done, o_nnz} !== {3'd0, 1'b0, 8'd1}) begin
            failures++; $display("FAIL basic_idle got=%0d/%b/%0d exp=0/0/1", o_state, o_done, o_nnz); end
        checks++; if (exp_a.size() + exp_b.size() != 0) begin
            failures++; $display("FAIL basic_pending got=%0d exp=0", exp_a.size() + exp_b.size()); end
    endtask

    task automatic test_reset_midload();
        rand_vector();
        do_start();
        load_vector();
        for (int j = 0; j < 5; j++) drive_beat(4'd0, 4'(j), 16'(j + 3), 1'b0);
        #3;
        i_rstn = 1'b0;
        i_valid = 1'b1; i_data = 16'h1234; i_last = 1'b1;
        #1;
        checks++; if ({o_state, o_nnz, o_ready, o_wr_en_A, o_wr_en_B, o_done, o_error} !== 16'd0) begin
            failures++; $display("FAIL midreset_outputs got=%0d/%0d/%b exp=0/0/00000",
                                 o_state, o_nnz, {o_ready, o_wr_en_A, o_wr_en_B, o_done, o_error}); end
        repeat (3) @(posedge i_clk);
        #3;
        i_valid = 1'b0; i_last = 1'b0;
        i_rstn = 1'b1;
        @(posedge i_clk); #1;
        checks++; if ({o_state, o_nnz} !== {3'd0, 8'd0}) begin
            failures++; $display("FAIL midreset_idle got=%0d/%0d exp=0/0", o_state, o_nnz); end
        checks++; if (exp_a.size() + exp_b.size() != 0) begin
            failures++; $display("FAIL midreset_pending got=%0d exp=0", exp_a.size() + exp_b.size()); end
    endtask

    task automatic test_full_word();
        bit seen;
        rand_vector();
        do_start();
        load_vector();
        for (int j = 0; j < 17; j++) begin
            bt_row[j] = 4'd0; bt_col[j] = 4'(j % 16); bt_val[j] = 16'(j + 1);
        end
        model_push(17);
        for (int j = 0; j < 15; j++) drive_beat(bt_row[j], bt_col[j], bt_val[j], 1'b0);
        checks++; if (o_wr_en_A !== 1'b0) begin failures++; $display("FAIL full_early got=%b exp=0", o_wr_en_A); end
        drive_beat(bt_row[15], bt_col[15], bt_val[15], 1'b0);
        checks++; if ({o_wr_en_A, o_address_A} !== {1'b1, 5'd1}) begin
            failures++; $display("FAIL full_write got=%b/%0d exp=1/1", o_wr_en_A, o_address_A); end
        drive_beat(bt_row[16], bt_col[16], bt_val[16], 1'b1);
        wait_done(seen);
        checks++; if (!seen) begin failures++; $display("FAIL full_done got=0 exp=1"); end
        checks++; if ({o_nnz, o_error} !== {8'd17, 1'b0}) begin
            failures++; $display("FAIL full_nnz got=%0d/%b exp=17/0", o_nnz, o_error); end
        checks++; if (exp_a.size() + exp_b.size() != 0) begin
            failures++; $display("FAIL full_pending got=%0d exp=0", exp_a.size() + exp_b.size()); end
    endtask

    task automatic test_row_ptr();
        bit seen;
        logic [255:0] rp;
        rand_vector();
        do_start();
        load_vector();
        bt_row[0] = 4'd0; bt_row[1] = 4'd2; bt_row[2] = 4'd2; bt_row[3] = 4'd5;
        for (int j = 0; j < 4; j++) begin
            bt_col[j] = 4'($urandom); bt_val[j] = 16'($urandom_range(1, 65535));
        end
        model_push(4);
        drive_beat(bt_row[0], bt_col[0], bt_val[0], 1'b0);
        i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        checks++; if (o_state !== 3'd2) begin failures++; $display("FAIL start_ignored got=%0d exp=2", o_state); end
        for (int j = 1; j < 4; j++) drive_beat(bt_row[j], bt_col[j], bt_val[j], j == 3);
        wait_done(seen);
        checks++; if (!seen) begin failures++; $display("FAIL rowptr_done got=0 exp=1"); end
        rp = '0;
        rp[1*8 +: 8] = 8'd1; rp[2*8 +: 8] = 8'd1;
        rp[3*8 +: 8] = 8'd3; rp[4*8 +: 8] = 8'd3; rp[5*8 +: 8] = 8'd3;
        for (int k = 6; k <= 16; k++) rp[k*8 +: 8] = 8'd4;
        checks++; if (last_rp !== rp) begin failures++; $display("FAIL rowptr_value got=%h exp=%h", last_rp, rp); end
        checks++; if ({o_nnz, o_error} !== {8'd4, 1'b0}) begin
            failures++; $display("FAIL rowptr_nnz got=%0d/%b exp=4/0", o_nnz, o_error); end
        checks++; if (exp_a.size() + exp_b.size() != 0) begin
            failures++; $display("FAIL rowptr_pending got=%0d exp=0", exp_a.size() + exp_b.size()); end
    endtask

    task automatic test_row_error();
        bit seen;
        rand_vector();
        do_start();
        load_vector();
        bt_row[0] = 4'd3; bt_col[0] = 4'd9; bt_val[0] = 16'h00aa;
        bt_row[1] = 4'd1; bt_col[1] = 4'd4; bt_val[1] = 16'h00bb;
        model_push(2);
        run_nz(2);
        wait_done(seen);
        checks++; if (!seen) begin failures++; $display("FAIL rowerr_done got=0 exp=1"); end
        checks++; if ({o_error, o_nnz} !== {1'b1, 8'd1}) begin
            failures++; $display("FAIL rowerr_flag got=%b/%0d exp=1/1", o_error, o_nnz); end
        checks++; if (exp_a.size() + exp_b.size() != 0) begin
            failures++; $display("FAIL rowerr_pending got=%0d exp=0", exp_a.size() + exp_b.size()); end
        do_start();
        checks++; if (o_error !== 1'b0) begin failures++; $display("FAIL rowerr_clear got=%b exp=0", o_error); end
        load_vector();
        bt_row[0] = 4'd7; bt_col[0] = 4'd2; bt_val[0] = 16'h0042;
        model_push(1);
        run_nz(1);
        wait_done(seen);
        checks++; if (!seen || o_error !== 1'b0 || o_nnz !== 8'd1) begin
            failures++; $display("FAIL rowerr_reload got=%b/%b/%0d exp=1/0/1", seen, o_error, o_nnz); end
    endtask

    task automatic test_overflow();
        bit seen;
        rand_vector();
        do_start();
        load_vector();
        for (int j = 0; j < 256; j++) begin
            bt_row[j] = 4'd0; bt_col[j] = 4'(j % 16); bt_val[j] = 16'(j + 1);
        end
        model_push(256);
        run_nz(256);
        wait_done(seen);
        checks++; if (!seen) begin failures++; $display("FAIL ovf_done got=0 exp=1"); end
        checks++; if ({o_error, o_nnz} !== {1'b1, 8'd255}) begin
            failures++; $display("FAIL ovf_flag got=%b/%0d exp=1/255", o_error, o_nnz); end
        checks++; if (exp_a.size() + exp_b.size() != 0) begin
            failures++; $display("FAIL ovf_pending got=%0d exp=0", exp_a.size() + exp_b.size()); end
    endtask

    task automatic test_zero_values();
        bit seen;
        logic [7:0] exp_nz;
`ifdef SPMV_LOADER_ZERO_SKIP_EN
        exp_nz = 8'd2;
`else
        exp_nz = 8'd3;
`endif
        rand_vector();
        do_start();
        load_vector();
        bt_row[0] = 4'd0; bt_col[0] = 4'd0; bt_val[0] = 16'd5;
        bt_row[1] = 4'd0; bt_col[1] = 4'd1; bt_val[1] = 16'd0;
        bt_row[2] = 4'd0; bt_col[2] = 4'd2; bt_val[2] = 16'd9;
        model_push(3);
        run_nz(3);
        wait_done(seen);
        checks++; if (!seen) begin failures++; $display("FAIL zero_done got=0 exp=1"); end
        checks++; if ({o_nnz, o_error} !== {exp_nz, 1'b0}) begin
            failures++; $display("FAIL zero_nnz got=%0d/%b exp=%0d/0", o_nnz, o_error, exp_nz); end
        checks++; if (exp_a.size() + exp_b.size() != 0) begin
            failures++; $display("FAIL zero_pending got=%0d exp=0", exp_a.size() + exp_b.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reset_midload();
        test_full_word();
        test_row_ptr();
        test_row_error();
        test_overflow();
        test_zero_values();
        repeat (2) @(posedge i_clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
